// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of words from a combinational-read memory
// and streams them out through a 2-entry FIFO with valid/ready handshake.
module ram_stream_reader #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [DATA_W-1:0]   fifo_data_q [2];
    logic [DATA_W-1:0]   fifo_data_d [2];
    logic [1:0]          fifo_last_q, fifo_last_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;

    logic pop;
    logic pop_eff;
    logic capture;
    logic abort_eff;
    logic last_word;

    // Handshake qualifiers; abort outranks any capture or pop in its cycle.
    always_comb begin
        abort_eff = abort && (state_q != IDLE);
        pop       = (count_q != 2'd0) && out_ready;
        pop_eff   = pop && !abort_eff;
        // A full FIFO can still take a word if the head leaves this cycle.
        capture   = (state_q == READ) && !abort_eff &&
                    ((count_q < 2'd2) || pop);
        last_word = (remaining_q == {{ADDR_W{1'b0}}, 1'b1});
    end

    // Datapath next-state: address/remaining counters and FIFO bookkeeping.
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (state_q == IDLE && start) begin
            addr_d      = base_addr;
            remaining_d = length;
        end

        if (capture) begin
            fifo_data_d[wr_ptr_q] = mem_data;
            fifo_last_d[wr_ptr_q] = last_word;
            wr_ptr_d              = ~wr_ptr_q;
            addr_d                = addr_q + 1'b1;   // wraps naturally
            remaining_d           = remaining_q - 1'b1;
        end

        if (pop_eff)
            rd_ptr_d = ~rd_ptr_q;

        case ({capture, pop_eff})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (abort_eff) begin
            count_d     = 2'd0;
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            remaining_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            remaining_q    <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            fifo_last_q    <= fifo_last_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state: DRAIN exits only once the last buffered word has left.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = (length == '0) ? DONE : READ;
            end
            READ: begin
                if (capture && last_word)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (count_d == 2'd0)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_eff)
            state_d = IDLE;
    end

    // FSM outputs; head data is gated so an empty FIFO shows zeros.
    always_comb begin
        mem_address = addr_q;
        mem_rd      = capture;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        out_valid   = (count_q != 2'd0);
        out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
        out_last    = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: per-cycle vector table plus
// hand-written stall, reset and start-while-busy sequences.
module tb_ram_stream_reader;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              abort;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // memory[k] = k, truncated to the word width
    assign mem_data = mem_address[DATA_W-1:0];

    ram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .mem_address(mem_address),
        .mem_data(mem_data), .mem_rd(mem_rd), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic              st;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   len;
        logic              ab;
        logic              rdy;
        logic              vld;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              bsy;
        logic              dn;
        logic              mrd;
    } vec_t;

    vec_t vecs [36];

    function automatic vec_t v(input logic st, input logic [ADDR_W-1:0] base,
                               input logic [ADDR_W:0] len, input logic ab,
                               input logic rdy, input logic vld,
                               input logic [DATA_W-1:0] data, input logic last,
                               input logic bsy, input logic dn, input logic mrd);
        vec_t r;
        r.st = st; r.base = base; r.len = len; r.ab = ab; r.rdy = rdy;
        r.vld = vld; r.data = data; r.last = last; r.bsy = bsy; r.dn = dn;
        r.mrd = mrd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Collect words with out_ready high until done, checking order and last.
    task automatic drain_check(input string nm, input logic [DATA_W-1:0] first,
                               input int nwords);
        int  got;
        bit  dn_seen;
        got = 0;
        dn_seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && !dn_seen; i++) begin
            #1;
            if (out_valid) begin
                chk($sformatf("%s_data%0d", nm, got), 32'(out_data), 32'(first + DATA_W'(got)));
                chk($sformatf("%s_last%0d", nm, got), 32'(out_last), 32'(got == nwords - 1));
                got++;
            end
            if (done) dn_seen = 1;
            @(posedge clk);
            #1;
        end
        chk({nm, "_count"}, 32'(got), 32'(nwords));
        chk({nm, "_done_seen"}, 32'(dn_seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rd_cnt;

        // burst of 4 from 0x10
        vecs[0]  = v(1, 'h10, 4, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[1]  = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 0, 1);
        vecs[2]  = v(0, 0, 0, 0, 1,     1, 'h10, 0, 1, 0, 1);
        vecs[3]  = v(0, 0, 0, 0, 1,     1, 'h11, 0, 1, 0, 1);
        vecs[4]  = v(0, 0, 0, 0, 1,     1, 'h12, 0, 1, 0, 1);
        vecs[5]  = v(0, 0, 0, 0, 1,     1, 'h13, 1, 1, 0, 0);
        vecs[6]  = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 1, 0);
        vecs[7]  = v(0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0);
        // zero-length burst
        vecs[8]  = v(1, 'h30, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[9]  = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 1, 0);
        vecs[10] = v(0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0);
        // address wrap
        vecs[11] = v(1, 'h3FFFE, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[12] = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 0, 1);
        vecs[13] = v(0, 0, 0, 0, 1,     1, 'hFFFE, 0, 1, 0, 1);
        vecs[14] = v(0, 0, 0, 0, 1,     1, 'hFFFF, 0, 1, 0, 1);
        vecs[15] = v(0, 0, 0, 0, 1,     1, 'h0000, 0, 1, 0, 1);
        vecs[16] = v(0, 0, 0, 0, 1,     1, 'h0001, 1, 1, 0, 0);
        vecs[17] = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 1, 0);
        vecs[18] = v(0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0);
        // abort after third transfer, then a 2-word burst
        vecs[19] = v(1, 'h20, 8, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[20] = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 0, 1);
        vecs[21] = v(0, 0, 0, 0, 1,     1, 'h20, 0, 1, 0, 1);
        vecs[22] = v(0, 0, 0, 0, 1,     1, 'h21, 0, 1, 0, 1);
        vecs[23] = v(0, 0, 0, 0, 1,     1, 'h22, 0, 1, 0, 1);
        vecs[24] = v(0, 0, 0, 1, 1,     1, 'h23, 0, 1, 0, 0);
        vecs[25] = v(1, 'h40, 2, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[26] = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 0, 1);
        vecs[27] = v(0, 0, 0, 0, 1,     1, 'h40, 0, 1, 0, 1);
        vecs[28] = v(0, 0, 0, 0, 1,     1, 'h41, 1, 1, 0, 0);
        vecs[29] = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 1, 0);
        vecs[30] = v(0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0);
        // abort together with start in IDLE: start wins
        vecs[31] = v(1, 'h60, 1, 1, 1,  0, 0, 0, 0, 0, 0);
        vecs[32] = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 0, 1);
        vecs[33] = v(0, 0, 0, 0, 1,     1, 'h60, 1, 1, 0, 0);
        vecs[34] = v(0, 0, 0, 0, 1,     0, 0, 0, 1, 1, 0);
        vecs[35] = v(0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0);

        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        abort = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(mem_address), 0);
        #9 rst_n = 1'b1;
        step();

        for (int i = 0; i < 36; i++) begin
            start = vecs[i].st; base_addr = vecs[i].base; length = vecs[i].len;
            abort = vecs[i].ab; out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("v%0d_mem_rd", i), 32'(mem_rd), 32'(vecs[i].mrd));
            if (vecs[i].vld) begin
                chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].data));
                chk($sformatf("v%0d_last", i), 32'(out_last), 32'(vecs[i].last));
            end
            step();
        end
        start = 1'b0; abort = 1'b0;

        // stall: 5 words, consumer blocked for 10 cycles
        start = 1'b1; base_addr = 'h50; length = 5; out_ready = 1'b0;
        step();
        start = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_rd) rd_cnt++;
            if (out_valid) begin
                chk($sformatf("stall_hold_data%0d", i), 32'(out_data), 32'h50);
                chk($sformatf("stall_hold_last%0d", i), 32'(out_last), 0);
            end
            step();
        end
        chk("stall_mem_rd_count", 32'(rd_cnt), 2);
        drain_check("stall", 'h50, 5);
        step();

        // reset asserted mid-burst acts immediately
        start = 1'b1; base_addr = 'h70; length = 8; out_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("mid_busy_before_rst", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_last", 32'(out_last), 0);
        chk("arst_mem_rd", 32'(mem_rd), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_addr", 32'(mem_address), 0);
        chk("arst_data", 32'(out_data), 0);
        #2 rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post_rst_done%0d", i), 32'(done), 0);
            chk($sformatf("post_rst_busy%0d", i), 32'(busy), 0);
            step();
        end

        // start while busy is ignored
        start = 1'b1; base_addr = 'h100; length = 3; out_ready = 1'b0;
        step();
        start = 1'b0;
        step(); step();
        start = 1'b1; base_addr = 'h200; length = 6;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("busy_ign_addr%0d", i), 32'(mem_address), 32'h102);
            chk($sformatf("busy_ign_busy%0d", i), 32'(busy), 1);
            step();
        end
        start = 1'b0;
        drain_check("busy_ign", 'h100, 3);
        #1;
        chk("final_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
